ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the CPU to the attached keyboard. It is the opposite direction of the existing receive-only PS/2 keyboard interface. It shares the same open-drain clock and data pins with that interface and sits on the CPU bus beside it, clocked by clk25 and qualified by cpu_clken. It performs the full request-to-send sequence, bit shifting with odd parity, ACK check and timeout.

## Interface
- INHIBIT_CYCLES, 2500: clk25 cycles the clock line is held low before the request (100 µs).
- TIMEOUT_CYCLES, 375000: maximum clk25 cycles from request start to ACK (15 ms).
- clk25  in  1  25 MHz master clock.
- rst  in  1  reset; rst is asynchronous, active-high; clock is clk25.
- enable  in  1  CPU clock enable; qualifies writes.
- w_en  in  1  write strobe; a byte is accepted when w_en & enable & ~busy.
- din  in  8  command byte.
- busy  out  1  transfer in progress; the receiver must ignore the line while it is high.
- done  out  1  one-cycle pulse when a transfer ends (success, NAK or timeout).
- ack_err  out  1  device did not ACK (data high on 11th clock); held until next accepted write.
- timeout  out  1  transfer aborted by timeout; held until next accepted write.
- ps2_clk_in  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin (asynchronous).
- ps2_clk_oe  out  1  1 = pull the clock line low; 0 = release it.
- ps2_data_oe  out  1  1 = pull the data line low; 0 = release it.

## Operation
- Inputs pass through a 2-flop synchronizer. A falling edge is detected as sync_prev=1 and sync=0.
- Frame: start(0), D0..D7 LSB first, odd parity (1 when din has an even number of ones), stop(1). Load shift register {stop, parity, din, start}. ps2_data_oe = ~current bit.
- States:
  - IDLE: both lines released. An accepted write loads the shift register, clears ack_err/timeout and goes to INHIBIT.
  - INHIBIT: clk_oe=1, data_oe=0. A counter runs INHIBIT_CYCLES cycles, then goes to REQ.
  - REQ: clk_oe=0, data_oe=1 (start bit driven). The timeout counter starts. Each falling edge of the device clock shifts the next bit onto data. Ten falling edges present D0..D7, parity and stop; the stop bit releases data. Then go to ACK.
  - ACK: on the 11th falling edge, sample data. Low = ACK; high sets ack_err. Then go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock and data are both high, pulse done, go to IDLE.
- Timeout: in REQ/ACK/WAIT_IDLE, when the counter reaches TIMEOUT_CYCLES, release both lines, set timeout, pulse done, go to IDLE.
- Writes while busy are ignored; din is not re-sampled mid-transfer.
- Reset (including mid-transfer): state IDLE; busy=done=ack_err=timeout=0; clk_oe=data_oe=0 (lines released immediately); counters cleared.

## Timing
- Write accepted in cycle N: busy=1 and clk_oe=1 from N+1.
- clk_oe stays high for exactly INHIBIT_CYCLES cycles. In the following cycle clk_oe=0 and data_oe=1 together (no cycle with both released).
- Pin falling edge to data_oe update: 3 clk25 cycles (2 sync + 1 register). This is well inside the ≥5 µs clock-low phase.
- The ACK sample uses the synced data value in the falling-edge detect cycle.
- done is high for exactly one cycle. busy drops in the same cycle done is high. ack_err/timeout are valid when done is high.
- busy stays high from acceptance until done, including through WAIT_IDLE.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz that ACKs. Required: INHIBIT of 2500 cycles, then the sampled bits 0,1,0,1,1,0,1,1,1, parity=1, stop=1, then one done pulse with ack_err=0 and timeout=0.
- Send 0x01 and 0xFF. Required parity bits 0 and 1; both complete with ack_err=0.
- Send 0xF4 with a device that leaves data high on the 11th clock. Required: done pulse with ack_err=1. ack_err clears on the next accepted write.
- Set TIMEOUT_CYCLES=1000 and give no device clocks. Required: done at 1000 cycles after REQ entry, timeout=1, both oe=0.
- Pulse w_en with 0x55 during a 0xED transfer. Required: the transfer continues with 0xED bits, and only one done pulse occurs.
- Assert rst after the 4th falling edge. Required: clk_oe=data_oe=busy=0 immediately. A new write then completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Sends one command byte to the attached keyboard: clock inhibit, request-to-send,
// LSB-first shift with odd parity and stop bit, ACK sample, then wait for an idle bus.
// A transfer ends with a one-cycle done pulse; ack_err/timeout report how it ended.
//
// Ports:
//   clk25        25 MHz master clock
//   rst          asynchronous active-high reset
//   enable       CPU clock enable qualifying writes
//   w_en, din    write strobe and command byte (accepted when w_en & enable & ~busy)
//   busy         transfer in progress
//   done         one-cycle pulse at end of transfer
//   ack_err      device did not ACK; held until the next accepted write
//   timeout      transfer aborted by timeout; held until the next accepted write
//   ps2_clk_in   raw PS/2 clock pin (asynchronous)
//   ps2_data_in  raw PS/2 data pin (asynchronous)
//   ps2_clk_oe   1 pulls the clock line low
//   ps2_data_oe  1 pulls the data line low
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       enable,
    input  logic       w_en,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned MaxCycles =
        (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StAck,
        StWaitIdle
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [10:0]     shift_q, shift_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            ack_err_q, ack_err_d;
    logic            timeout_q, timeout_d;
    logic            done_q, done_d;

    // [0] first flop, [1] synced value, [2] previous synced value (clock only)
    logic [2:0] clk_sync_q;
    logic [1:0] data_sync_q;

    logic clk_sync, data_sync, clk_fall;

    assign clk_sync  = clk_sync_q[1];
    assign data_sync = data_sync_q[1];
    assign clk_fall  = clk_sync_q[2] & ~clk_sync_q[1];

    // Synchronizers reset to 1 so an idle bus never looks like a falling edge.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shift_q   <= '1;
            bit_cnt_q <= '0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (w_en && enable) begin
                    // {stop, odd parity, data, start}
                    shift_d   = {1'b1, ~^din, din, 1'b0};
                    ack_err_d = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == CntW'(INHIBIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = StReq;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReq, StAck, StWaitIdle: begin
                if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (state_q == StReq) begin
                        if (clk_fall) begin
                            shift_d   = {1'b1, shift_q[10:1]};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            // Tenth edge puts the stop bit out, releasing data.
                            if (bit_cnt_q == 4'd9) begin
                                state_d = StAck;
                            end
                        end
                    end else if (state_q == StAck) begin
                        if (clk_fall) begin
                            ack_err_d = data_sync;
                            state_d   = StWaitIdle;
                        end
                    end else begin
                        if (clk_sync && data_sync) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout     = timeout_q;
    assign ps2_clk_oe  = (state_q == StInhibit);
    assign ps2_data_oe = ((state_q == StReq) || (state_q == StAck)) && !shift_q[0];

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int unsigned INH  = 2500;
    localparam int unsigned INH2 = 20;
    localparam int unsigned TO2  = 1000;

    logic clk25 = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic w_en = 1'b0;
    logic [7:0] din = 8'h00;
    logic busy, done, ack_err, timeout, clk_oe, data_oe;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic clk_in, data_in;

    logic w_en2 = 1'b0;
    logic [7:0] din2 = 8'h00;
    logic busy2, done2, ack_err2, timeout2, clk_oe2, data_oe2;
    logic clk_in2, data_in2;

    // Open-drain bus: a line is low if either side pulls it.
    assign clk_in   = dev_clk & ~clk_oe;
    assign data_in  = dev_data & ~data_oe;
    assign clk_in2  = ~clk_oe2;
    assign data_in2 = ~data_oe2;

    always #20 clk25 = ~clk25;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(375000)) dut (
        .clk25(clk25), .rst(rst), .enable(enable), .w_en(w_en), .din(din),
        .busy(busy), .done(done), .ack_err(ack_err), .timeout(timeout),
        .ps2_clk_in(clk_in), .ps2_data_in(data_in),
        .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe)
    );

    ps2_host_tx #(.INHIBIT_CYCLES(INH2), .TIMEOUT_CYCLES(TO2)) dut_to (
        .clk25(clk25), .rst(rst), .enable(enable), .w_en(w_en2), .din(din2),
        .busy(busy2), .done(done2), .ack_err(ack_err2), .timeout(timeout2),
        .ps2_clk_in(clk_in2), .ps2_data_in(data_in2),
        .ps2_clk_oe(clk_oe2), .ps2_data_oe(data_oe2)
    );

    int checks = 0;
    int errors = 0;

    int   done_cnt = 0;
    logic last_ack_err = 1'b0;
    logic last_timeout = 1'b0;
    logic last_busy = 1'b0;

    always @(negedge clk25) begin
        if (done === 1'b1) begin
            done_cnt     <= done_cnt + 1;
            last_ack_err <= ack_err;
            last_timeout <= timeout;
            last_busy    <= busy;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    // Keyboard model: waits for request-to-send, clocks 10 bits in (sampled on
    // the rising edge), then ACKs (or not) on the 11th clock.
    task automatic device(input bit nak, input int half, output logic [9:0] got);
        int n = 0;
        got = '0;
        while (!(clk_in === 1'b1 && data_in === 1'b0) && n < 1000) begin
            tick(1);
            n++;
        end
        check("device_saw_request", n < 1000, 1);
        tick(half);
        for (int i = 0; i < 10; i++) begin
            dev_clk = 1'b0;
            tick(half);
            dev_clk = 1'b1;
            got[i] = data_in;
            tick(half);
        end
        if (!nak) dev_data = 1'b0;
        tick(5);
        dev_clk = 1'b0;
        tick(half);
        dev_clk = 1'b1;
        tick(5);
        dev_data = 1'b1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        tick(1);
        w_en = 1'b1;
        din  = d;
        tick(1);
        w_en = 1'b0;
        din  = 8'($urandom);
    endtask

    task automatic transfer(input logic [7:0] d, input bit nak, input int half, input bit poke,
                            input logic exp_err, output logic [9:0] got);
        int n;
        int d0;
        logic [9:0] exp_frame;
        // Frame model: data LSB first, then a parity bit making the total odd, then stop.
        exp_frame = {1'b1, ($countones(d) % 2 == 0), d};
        d0 = done_cnt;
        write_byte(d);
        check("busy_after_accept", busy, 1);
        check("clk_oe_after_accept", clk_oe, 1);
        check("ack_err_cleared", ack_err, 0);
        check("timeout_cleared", timeout, 0);
        n = 0;
        while (clk_oe === 1'b1 && n < INH + 100) begin
            tick(1);
            n++;
        end
        check("inhibit_len", n, INH);
        check("req_start_bit", data_oe, 1);
        fork
            device(nak, half, got);
            begin
                if (poke) begin
                    tick(5 * half);
                    w_en = 1'b1;
                    din  = 8'h55;
                    tick(1);
                    w_en = 1'b0;
                end
            end
        join
        check("frame_bits", got, exp_frame);
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            tick(1);
            n++;
        end
        tick(50);
        check("done_once", done_cnt - d0, 1);
        check("ack_err_at_done", last_ack_err, exp_err);
        check("timeout_at_done", last_timeout, 0);
        check("busy_low_with_done", last_busy, 0);
        check("idle_busy", busy, 0);
        check("idle_oe", {clk_oe, data_oe}, 0);
    endtask

    typedef struct {
        logic [7:0] din;
        bit         nak;
        int         half;
        bit         poke;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [9:0] got;
        int n;
        int d0;

        vecs[0] = '{din: 8'hED, nak: 1'b0, half: 1000, poke: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
        vecs[1] = '{din: 8'h01, nak: 1'b0, half: 30, poke: 1'b0, exp_par: 1'b0, exp_err: 1'b0};
        vecs[2] = '{din: 8'hFF, nak: 1'b0, half: 30, poke: 1'b0, exp_par: 1'b1, exp_err: 1'b0};
        vecs[3] = '{din: 8'hF4, nak: 1'b1, half: 30, poke: 1'b0, exp_par: 1'b0, exp_err: 1'b1};
        vecs[4] = '{din: 8'hED, nak: 1'b0, half: 30, poke: 1'b1, exp_par: 1'b1, exp_err: 1'b0};

        tick(3);
        check("reset_state", {busy, done, ack_err, timeout, clk_oe, data_oe}, 0);
        rst = 1'b0;
        tick(3);

        // Timeout with no device clocks.
        tick(1);
        w_en2 = 1'b1;
        din2  = 8'hED;
        tick(1);
        w_en2 = 1'b0;
        n = 0;
        while (clk_oe2 === 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("to_inhibit_len", n, INH2);
        n = 0;
        while (done2 !== 1'b1 && n < 2 * TO2) begin
            tick(1);
            n++;
        end
        check("to_cycles", n, TO2);
        check("to_flag", timeout2, 1);
        check("to_ack_err", ack_err2, 0);
        check("to_busy", busy2, 0);
        check("to_oe", {clk_oe2, data_oe2}, 0);
        tick(1);
        check("to_done_pulse", done2, 0);

        for (int i = 0; i < 5; i++) begin
            transfer(vecs[i].din, vecs[i].nak, vecs[i].half, vecs[i].poke, vecs[i].exp_err, got);
            check("parity_bit", got[8], vecs[i].exp_par);
        end

        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            bit nk;
            d  = 8'($urandom);
            nk = bit'($urandom_range(0, 1));
            transfer(d, nk, int'($urandom_range(20, 50)), 1'b0, nk, got);
        end

        // Reset after the 4th falling edge.
        d0 = done_cnt;
        write_byte(8'hA5);
        n = 0;
        while (clk_oe === 1'b1 && n < INH + 100) begin
            tick(1);
            n++;
        end
        tick(20);
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b0;
            tick(30);
            if (i < 3) begin
                dev_clk = 1'b1;
                tick(30);
            end
        end
        check("mid_busy", busy, 1);
        #5;
        rst = 1'b1;
        #1;
        check("rst_immediate", {busy, clk_oe, data_oe, done}, 0);
        dev_clk = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_flags", {ack_err, timeout}, 0);
        check("rst_no_done", done_cnt - d0, 0);
        transfer(8'h3C, 1'b0, 30, 1'b0, 1'b0, got);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
